// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Imported by the FIFO and the serializer top.
package uart_tx_pkg;

    localparam int MAX_FRAME_BITS = 12;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic par_enabled(parity_e p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the serializer.
// Reports occupancy and flags a dropped push one cycle later.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              ovf_q;
    logic              push;
    logic              pop;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign ovf_o     = ovf_q;
    assign rd_data_o = mem[rd_ptr_q];

    // Full blocks a push even when a pop frees a slot this cycle.
    assign push = wr_en_i & ~full_o;
    assign pop  = rd_en_i & ~empty_o;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= wr_en_i & full_o;
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO, baud counter, frame FSM.
// Line settings are captured per frame when a word is popped.
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [DIV_W-1:0]           divider_i,
    input  logic [1:0]                 parity_i,
    input  logic                       stop2_i,
    input  logic                       wr_req_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       wr_ack_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic                       busy_o,
    output logic                       tx_o
);

    localparam int BC_W = $clog2(DATA_W) + 1;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] fifo_data;
    logic              load;
    logic [DIV_W-1:0]  div_eff;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt_q;
    parity_e           par_q;
    logic              stop2_q;
    logic              stop_idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              par_bit_q;
    logic              tx_q, tx_d;
    logic              bit_end;
    logic              last_data;
    logic              last_stop;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .wr_en_i   (wr_req_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (load),
        .rd_data_o (fifo_data),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .level_o   (level_o),
        .ovf_o     (ovf_o)
    );

    assign wr_ack_o  = wr_req_i & ~full_o;
    assign div_eff   = (divider_i == '0) ? DIV_W'(1) : divider_i;
    assign bit_end   = (cnt_q == '0);
    assign last_data = (bit_cnt_q == BC_W'(DATA_W - 1));
    assign last_stop = stop2_q ? stop_idx_q : 1'b1;

    // A pop from STOP chains straight into the next start bit.
    assign load = ~empty_o &
                  ((state_q == ST_IDLE) |
                   ((state_q == ST_STOP) & bit_end & last_stop));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (!empty_o)
                    state_d = ST_START;
            ST_START:
                if (bit_end)
                    state_d = ST_DATA;
            ST_DATA:
                if (bit_end && last_data)
                    state_d = par_enabled(par_q) ? ST_PARITY : ST_STOP;
            ST_PARITY:
                if (bit_end)
                    state_d = ST_STOP;
            ST_STOP:
                if (bit_end && last_stop)
                    state_d = empty_o ? ST_IDLE : ST_START;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_o = (state_q != ST_IDLE);
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q      <= '0;
            div_q      <= DIV_W'(1);
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_q <= tx_d;
            if (load) begin
                shreg_q    <= fifo_data;
                div_q      <= div_eff;
                cnt_q      <= div_eff - DIV_W'(1);
                par_q      <= parity_e'(parity_i);
                stop2_q    <= stop2_i;
                stop_idx_q <= 1'b0;
                bit_cnt_q  <= '0;
                par_bit_q  <= (^fifo_data) ^
                              (parity_e'(parity_i) == PAR_ODD);
            end else if (state_q != ST_IDLE) begin
                if (bit_end) begin
                    cnt_q <= div_q - DIV_W'(1);
                    if (state_q == ST_DATA) begin
                        shreg_q   <= {1'b0, shreg_q[DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    end
                    if (state_q == ST_STOP)
                        stop_idx_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - DIV_W'(1);
                end
            end
        end
    end

    assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (DATA_W=8, DEPTH=4, DIV_W=16).
// Samples 1 time unit after each rising clock edge.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        arst;
    logic [15:0] divider;
    logic [1:0]  parity;
    logic        stop2;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic        ovf;
    logic        busy;
    logic        tx;

    int checks = 0;
    int errors = 0;

    uart_tx_cfg #(
        .DATA_W (8),
        .DEPTH  (4),
        .DIV_W  (16)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst),
        .divider_i (divider),
        .parity_i  (parity),
        .stop2_i   (stop2),
        .wr_req_i  (wr_req),
        .wr_data_i (wr_data),
        .wr_ack_o  (wr_ack),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level),
        .ovf_o     (ovf),
        .busy_o    (busy),
        .tx_o      (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_req  = 1'b1;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    // Samples one full frame; the next tick must show the start bit.
    task automatic expect_frame(input string tag, input logic [7:0] d,
                                input bit par_en, input bit par_bit,
                                input bit two_stop, input int div,
                                input int chg_idx, input logic [15:0] chg_div);
        logic [11:0] bits;
        int nb;
        int k;
        int bad;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            bits[1+i] = d[i];
        nb = 9;
        if (par_en) begin
            bits[nb] = par_bit;
            nb++;
        end
        nb += two_stop ? 2 : 1;
        k = 0;
        bad = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < div; c++) begin
                if (k == chg_idx)
                    divider = chg_div;
                tick();
                if (tx !== bits[b])
                    bad++;
                k++;
            end
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int n;
        int bad;
        arst    = 1'b1;
        divider = 16'd4;
        parity  = 2'd0;
        stop2   = 1'b0;
        wr_req  = 1'b0;
        wr_data = 8'h00;
        tick();
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        arst = 1'b0;
        tick();

        // 8N1, divider 4, 0x55
        push(8'h55);
        chk("t1_level", level, 1);
        chk("t1_tx_n", tx, 1);
        tick();
        chk("t1_tx_n1", tx, 1);
        chk("t1_busy", busy, 1);
        chk("t1_empty", empty, 1);
        expect_frame("t1_frame55", 8'h55, 0, 0, 0, 4, -1, 16'd0);
        chk("t1_idle", busy, 0);

        // Even then odd parity, divider 2, 0x07
        divider = 16'd2;
        parity  = 2'd1;
        push(8'h07);
        tick();
        expect_frame("t2_even", 8'h07, 1, 1, 0, 2, -1, 16'd0);
        chk("t2_idle_even", busy, 0);
        parity = 2'd2;
        push(8'h07);
        tick();
        expect_frame("t2_odd", 8'h07, 1, 0, 0, 2, -1, 16'd0);
        chk("t2_idle_odd", busy, 0);

        // Two stop bits, back-to-back frames
        parity  = 2'd0;
        stop2   = 1'b1;
        divider = 16'd3;
        push(8'hA0);
        push(8'h0F);
        expect_frame("t3_fA0", 8'hA0, 0, 0, 1, 3, -1, 16'd0);
        expect_frame("t3_f0F", 8'h0F, 0, 0, 1, 3, -1, 16'd0);
        chk("t3_idle", busy, 0);

        // Overflow with DEPTH=4 while busy
        stop2   = 1'b0;
        divider = 16'd2;
        push(8'h11);
        tick();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            wr_data = 8'hA1 + 8'(i);
            #1;
            chk($sformatf("t4_ack%0d", i), wr_ack, (i < 4) ? 1 : 0);
            tick();
            n++;
            if (i == 3) begin
                chk("t4_level_peak", level, 4);
                chk("t4_full", full, 1);
                chk("t4_no_ovf", ovf, 0);
            end
        end
        wr_req = 1'b0;
        chk("t4_ovf", ovf, 1);
        chk("t4_level_hold", level, 4);
        tick();
        n++;
        chk("t4_ovf_pulse", ovf, 0);
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("t4_busy_cycles", n, 100);
        chk("t4_empty", empty, 1);
        chk("t4_level_end", level, 0);

        // Divider change mid-frame, then divider 0
        divider = 16'd4;
        push(8'h3C);
        push(8'hC3);
        expect_frame("t5_div4", 8'h3C, 0, 0, 0, 4, 8, 16'd8);
        expect_frame("t5_div8", 8'hC3, 0, 0, 0, 8, -1, 16'd0);
        chk("t5_idle", busy, 0);
        divider = 16'd0;
        push(8'h5A);
        tick();
        expect_frame("t5_div0", 8'h5A, 0, 0, 0, 1, -1, 16'd0);
        chk("t5_idle0", busy, 0);

        // Reset during DATA bit 3 with two words queued
        divider = 16'd4;
        push(8'h00);
        push(8'hFF);
        push(8'h81);
        chk("t6_level", level, 2);
        for (int i = 0; i < 17; i++)
            tick();
        chk("t6_tx_low", tx, 0);
        arst = 1'b1;
        #1;
        chk("t6_async_tx", tx, 1);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_empty", empty, 1);
        chk("t6_async_level", level, 0);
        tick();
        tick();
        arst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        chk("t6_quiet", bad, 0);
        chk("t6_empty_end", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
